// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter: request side (ce/start/bcd)
// and result side (busy/done/q/err/ovf).
interface bcd_to_bin_if #(
   parameter int unsigned IN_DECADES   = 4,
   parameter int unsigned OUT_BITS_NUM = 14
);
   logic                      ce;
   logic                      start;
   logic [4*IN_DECADES-1:0]   bcd;
   logic                      busy;
   logic                      done;
   logic [OUT_BITS_NUM-1:0]   q;
   logic                      err;
   logic                      ovf;

   modport master (
      output ce, start, bcd,
      input  busy, done, q, err, ovf
   );

   modport slave (
      input  ce, start, bcd,
      output busy, done, q, err, ovf
   );
endinterface

// File: rtl/bcd_to_bin_conv.sv
// Iterative BCD-to-binary converter, Horner method MSD first, one decade per CE cycle.
// Optional macro BCD_TO_BIN_SAT_EN: saturate q to all-ones when the result overflows.
module bcd_to_bin_conv #(
   parameter int unsigned IN_DECADES   = 4,
   parameter int unsigned OUT_BITS_NUM = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   bcd_to_bin_if.slave  bus
);
   localparam int unsigned IN_W   = 4 * IN_DECADES;
   localparam int unsigned FULL_W = OUT_BITS_NUM + 4;
   localparam int unsigned CNT_W  = $clog2(IN_DECADES + 1);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t                  state_q, state_d;
   logic [IN_W-1:0]         sreg_q, sreg_d;
   logic [OUT_BITS_NUM-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_s_q, err_s_d;
   logic                    ovf_s_q, ovf_s_d;
   logic [OUT_BITS_NUM-1:0] q_q, q_d;
   logic                    err_q, err_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   logic [3:0]              digit_c;
   logic [FULL_W-1:0]       acc_ext_c;
   logic [FULL_W-1:0]       full_c;
   logic                    step_ovf_c;
   logic                    step_err_c;

   // One Horner step: acc*10 + digit, built from shifts, kept 4 bits wider to see overflow
   assign digit_c    = sreg_q[IN_W-1 -: 4];
   assign acc_ext_c  = FULL_W'(acc_q);
   assign full_c     = (acc_ext_c << 3) + (acc_ext_c << 1) + FULL_W'(digit_c);
   assign step_ovf_c = |full_c[FULL_W-1:OUT_BITS_NUM];
   assign step_err_c = (digit_c > 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_s_q <= 1'b0;
         ovf_s_q <= 1'b0;
         q_q     <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_s_q <= err_s_d;
         ovf_s_q <= ovf_s_d;
         q_q     <= q_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath; done is a one-clock pulse independent of ce
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_s_d = err_s_q;
      ovf_s_d = ovf_s_q;
      q_d     = q_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.ce && bus.start) begin
               sreg_d  = bus.bcd;
               acc_d   = '0;
               cnt_d   = CNT_W'(IN_DECADES);
               err_s_d = 1'b0;
               ovf_s_d = 1'b0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            if (bus.ce) begin
               acc_d   = full_c[OUT_BITS_NUM-1:0];
               err_s_d = err_s_q | step_err_c;
               ovf_s_d = ovf_s_q | step_ovf_c;
               sreg_d  = sreg_q << 4;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  err_d   = err_s_d;
                  ovf_d   = ovf_s_d;
`ifdef BCD_TO_BIN_SAT_EN
                  q_d     = ovf_s_d ? '1 : full_c[OUT_BITS_NUM-1:0];
`else
                  q_d     = full_c[OUT_BITS_NUM-1:0];
`endif
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_CONV);
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.q    = q_q;
   assign bus.err  = err_q;
   assign bus.ovf  = ovf_q;
endmodule
